fixed_round_sat: RTL and testbench
==================================

FIXED_ROUND_SAT -- requirements
Module: fixed_round_sat

Interface
REQ-001 SHALL have parameter DATA_IN_0_PRECISION_0, default 16, meaning input word width.
REQ-002 SHALL have parameter DATA_IN_0_PRECISION_1, default 8, meaning input fractional bits.
REQ-003 SHALL have parameter DATA_OUT_0_PRECISION_0, default 8, meaning output word width.
REQ-004 SHALL have parameter DATA_OUT_0_PRECISION_1, default 4, meaning output fractional bits.
REQ-005 SHALL have parameters DATA_IN_0_PARALLELISM_DIM_0 and DATA_IN_0_PARALLELISM_DIM_1, default 1 each; lane count N is their product.
REQ-006 SHALL have parameter SAT_CNT_WIDTH, default 16, meaning saturation counter width.
REQ-007 SHALL have port clk, input, 1 bit, the single clock.
REQ-008 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-009 SHALL have port data_in_0, input, N lanes of DATA_IN_0_PRECISION_0 bits, signed fixed-point samples from the upstream activation stage.
REQ-010 SHALL have ports data_in_0_valid (input, 1 bit) and data_in_0_ready (output, 1 bit), the input handshake.
REQ-011 SHALL have port data_out_0, output, N lanes of DATA_OUT_0_PRECISION_0 bits, the requantised samples.
REQ-012 SHALL have ports data_out_0_valid (output, 1 bit) and data_out_0_ready (input, 1 bit), the output handshake.
REQ-013 SHALL have port sat_clear, input, 1 bit, synchronous clear of sat_count.
REQ-014 SHALL have port sat_count, output, SAT_CNT_WIDTH bits, the count of output beats with any saturated lane.

Function
REQ-015 SHALL define SHIFT = DATA_IN_0_PRECISION_1 - DATA_OUT_0_PRECISION_1 and SHALL fail elaboration if SHIFT < 0 or DATA_OUT_0_PRECISION_0 > DATA_IN_0_PRECISION_0.
REQ-016 SHALL transfer a beat on either side only when valid and ready are both high on a rising clk edge.
REQ-017 SHALL drive data_in_0_ready directly from a flop: a one-entry skid register absorbs the single beat accepted while downstream stalls.
REQ-018 Stage 1 SHALL compute per lane, with one guard bit, sum = sign-extended input + (SHIFT>0 ? 2^(SHIFT-1) : 0), then arithmetic right shift by SHIFT (round half up).
REQ-019 Stage 2 SHALL clamp each lane to [-2^(W-1), 2^(W-1)-1], where W = DATA_OUT_0_PRECISION_0, and register the result together with a per-beat saturated flag (OR over lanes).
REQ-020 Latency SHALL be 2 cycles from input acceptance to data_out_0_valid when there is no backpressure; throughput SHALL be one beat per cycle sustained.
REQ-021 Each stage SHALL advance when it is empty or its downstream consumer takes its beat in the same cycle; no beat SHALL be dropped or duplicated under any valid/ready pattern.
REQ-022 data_out_0 and data_out_0_valid SHALL stay stable while data_out_0_valid=1 and data_out_0_ready=0.
REQ-023 sat_count SHALL increment by one on each output transfer whose flag is set, and SHALL hold at its all-ones value instead of wrapping.
REQ-024 When sat_clear and an increment occur in the same cycle, clear SHALL win and sat_count SHALL become 0.
REQ-025 SHALL be lane-independent; lane i of output SHALL depend only on lane i of input.

Reset
REQ-026 When rst_n=0, all stage valids, the skid entry, data_out_0_valid, and sat_count SHALL clear to 0 asynchronously, and data_out_0 SHALL be 0.
REQ-027 data_in_0_ready SHALL be 0 during reset and SHALL rise on the first clk edge after rst_n deasserts.
REQ-028 Reset mid-stream SHALL discard all in-flight beats; no stale beat SHALL appear after reset.

Structure
REQ-029 A shared package fixed_arith_pkg SHALL hold SHIFT computation and the saturation max/min constant functions, for reuse by other fixed_* stages.
REQ-030 The input skid register SHALL be the sub-module fixed_skid_buffer; the rounding and saturation logic SHALL be inline.

Verification (defaults: Q8.8 to Q4.4, SHIFT=4, N=1)
REQ-031 Input 0x0128 -> 0x13 after 2 cycles, flag 0; input 0xFFF8 -> 0x00; input 0xFFF7 -> 0xFF.
REQ-032 Input 0x7FFF -> 0x7F and input 0x8000 -> 0x80, each incrementing sat_count by 1.
REQ-033 Streaming 0..99 with data_out_0_ready toggled randomly -> exact in-order outputs, none lost or duplicated, and outputs stable while stalled.
REQ-034 Hold data_out_0_ready=0 with valid high -> data_in_0_ready falls after at most 3 accepted beats; on release, the beats drain in order.
REQ-035 With SAT_CNT_WIDTH=2, send 5 saturating beats -> sat_count=3; assert sat_clear during a saturating transfer -> sat_count=0.
REQ-036 Assert rst_n low with 2 beats in flight -> data_out_0_valid=0 immediately, and no old data appears after release.

Source files
------------

// File: rtl/fixed_arith_pkg.sv
// ---------------------------------------------------------------------------
// fixed_arith_pkg: shared constant helpers for the fixed_* requantiser stages.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fixed_arith_pkg;

  function automatic int calc_shift(input int in_frac, input int out_frac);
    return in_frac - out_frac;
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  // Half an output LSB expressed in input LSBs; zero when no bits are dropped.
  function automatic longint round_bias(input int shift);
    return (shift > 0) ? (longint'(1) <<< (shift - 1)) : longint'(0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fixed_skid_buffer.sv
// ---------------------------------------------------------------------------
// fixed_skid_buffer: registered-ready input stage with a one-entry skid slot.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fixed_skid_buffer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic             ready_q, ready_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             accept;

  assign accept = in_valid_i & ready_q;

  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (skid_valid_q) begin
      if (out_ready_i) skid_valid_d = 1'b0;
    end else if (accept && !out_ready_i) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
    // Ready is withheld for the whole cycle the slot is occupied.
    ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q      <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      ready_q      <= ready_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = skid_valid_q | accept;
  assign out_data_o  = skid_valid_q ? skid_data_q : in_data_i;

endmodule

`default_nettype wire

// File: rtl/fixed_round_sat.sv
// ---------------------------------------------------------------------------
// fixed_round_sat: two-stage round-half-up and saturate requantiser, N lanes.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fixed_round_sat
  import fixed_arith_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0       = 16,
  parameter int DATA_IN_0_PRECISION_1       = 8,
  parameter int DATA_OUT_0_PRECISION_0      = 8,
  parameter int DATA_OUT_0_PRECISION_1      = 4,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int SAT_CNT_WIDTH               = 16
) (
  input  logic                                                              clk,
  input  logic                                                              rst_n,
  input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0]
               [DATA_IN_0_PRECISION_0-1:0]                                  data_in_0,
  input  logic                                                              data_in_0_valid,
  output logic                                                              data_in_0_ready,
  output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0]
               [DATA_OUT_0_PRECISION_0-1:0]                                 data_out_0,
  output logic                                                              data_out_0_valid,
  input  logic                                                              data_out_0_ready,
  input  logic                                                              sat_clear,
  output logic [SAT_CNT_WIDTH-1:0]                                          sat_count
);

  localparam int N     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int IN_W  = DATA_IN_0_PRECISION_0;
  localparam int OUT_W = DATA_OUT_0_PRECISION_0;
  localparam int SHIFT = calc_shift(DATA_IN_0_PRECISION_1, DATA_OUT_0_PRECISION_1);
  localparam int SUM_W = IN_W + 1;

  localparam logic signed [SUM_W-1:0] ROUND   = SUM_W'(round_bias(SHIFT));
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(sat_max(OUT_W));
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(sat_min(OUT_W));

  if (SHIFT < 0 || OUT_W > IN_W) begin : g_param_check
    $error("fixed_round_sat: output precision must not exceed input precision");
  end

  logic [N-1:0][IN_W-1:0]  skid_data;
  logic                    skid_valid;
  logic                    s1_ready, s2_ready;

  logic                    s1_valid_q;
  logic [N-1:0][SUM_W-1:0] s1_data_q, s1_data_d;
  logic                    s2_valid_q;
  logic [N-1:0][OUT_W-1:0] s2_data_q, s2_data_d;
  logic                    s2_sat_q, s2_sat_d;
  logic [N-1:0]            lane_sat;
  logic [SAT_CNT_WIDTH-1:0] sat_count_q, sat_count_d;

  assign s2_ready = ~s2_valid_q | data_out_0_ready;
  assign s1_ready = ~s1_valid_q | s2_ready;

  fixed_skid_buffer #(
    .WIDTH(N * IN_W)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data_i  (data_in_0),
    .in_valid_i (data_in_0_valid),
    .in_ready_o (data_in_0_ready),
    .out_data_o (skid_data),
    .out_valid_o(skid_valid),
    .out_ready_i(s1_ready)
  );

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] rounded;
    logic                    over, under;

    // Guard bit keeps the rounding bias from wrapping the most positive input.
    assign sum          = $signed({skid_data[i][IN_W-1], skid_data[i]}) + ROUND;
    assign s1_data_d[i] = sum >>> SHIFT;

    assign rounded      = $signed(s1_data_q[i]);
    assign over         = rounded > SAT_MAX;
    assign under        = rounded < SAT_MIN;
    assign lane_sat[i]  = over | under;
    assign s2_data_d[i] = over  ? SAT_MAX[OUT_W-1:0] :
                          under ? SAT_MIN[OUT_W-1:0] : rounded[OUT_W-1:0];
  end

  assign s2_sat_d = |lane_sat;

  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clear) begin
      sat_count_d = '0;
    end else if (s2_valid_q && data_out_0_ready && s2_sat_q && !(&sat_count_q)) begin
      sat_count_d = sat_count_q + SAT_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_sat_q    <= 1'b0;
      sat_count_q <= '0;
    end else begin
      if (s1_ready) begin
        s1_valid_q <= skid_valid;
        if (skid_valid) s1_data_q <= s1_data_d;
      end
      if (s2_ready) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s2_data_d;
          s2_sat_q  <= s2_sat_d;
        end
      end
      sat_count_q <= sat_count_d;
    end
  end

  assign data_out_0       = s2_data_q;
  assign data_out_0_valid = s2_valid_q;
  assign sat_count        = sat_count_q;

endmodule

`default_nettype wire

// File: tb/tb_fixed_round_sat.sv
// ---------------------------------------------------------------------------
// tb_fixed_round_sat: directed + randomized bench for fixed_round_sat (Q8.8 -> Q4.4).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fixed_round_sat;

  localparam int IW = 16;
  localparam int OW = 8;
  localparam int SH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [0:0][IW-1:0] data_in_0 = '0;
  logic            data_in_0_valid = 1'b0;
  logic            data_out_0_ready = 1'b0;
  logic            sat_clear = 1'b0;

  logic            data_in_0_ready;
  logic [0:0][OW-1:0] data_out_0;
  logic            data_out_0_valid;
  logic [15:0]     sat_count;

  logic            data_in_0_ready_w2;
  logic [0:0][OW-1:0] data_out_0_w2;
  logic            data_out_0_valid_w2;
  logic [1:0]      sat_count_w2;

  int errors = 0;
  int checks = 0;

  logic [8:0]  exp_q[$];
  int          m16 = 0;
  int          m2 = 0;
  bit          stalled = 1'b0;
  logic [7:0]  held = '0;
  bit          last_acc = 1'b0;

  always #5 clk = ~clk;

  fixed_round_sat dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .data_in_0       (data_in_0),
    .data_in_0_valid (data_in_0_valid),
    .data_in_0_ready (data_in_0_ready),
    .data_out_0      (data_out_0),
    .data_out_0_valid(data_out_0_valid),
    .data_out_0_ready(data_out_0_ready),
    .sat_clear       (sat_clear),
    .sat_count       (sat_count)
  );

  fixed_round_sat #(.SAT_CNT_WIDTH(2)) dut_w2 (
    .clk             (clk),
    .rst_n           (rst_n),
    .data_in_0       (data_in_0),
    .data_in_0_valid (data_in_0_valid),
    .data_in_0_ready (data_in_0_ready_w2),
    .data_out_0      (data_out_0_w2),
    .data_out_0_valid(data_out_0_valid_w2),
    .data_out_0_ready(data_out_0_ready),
    .sat_clear       (sat_clear),
    .sat_count       (sat_count_w2)
  );

  // Reference: real-valued x / 2^SH rounded half up, then clamped to OW bits.
  function automatic logic [8:0] ref_model(input logic [IW-1:0] x);
    int v, q, y;
    bit s;
    v = int'($signed(x));
    q = v + (1 << (SH - 1));
    y = (q >= 0) ? q / (1 << SH) : -((-q + (1 << SH) - 1) / (1 << SH));
    s = 1'b0;
    if (y > 127) begin y = 127; s = 1'b1; end
    else if (y < -128) begin y = -128; s = 1'b1; end
    return {s, 8'(y)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, score the transfers of the coming edge, advance.
  task automatic step(input bit vin, input logic [IW-1:0] din, input bit ordy, input bit clr);
    logic [8:0] e;
    data_in_0_valid  = vin;
    data_in_0        = din;
    data_out_0_ready = ordy;
    sat_clear        = clr;
    if (stalled) begin
      chk("hold_valid", {31'b0, data_out_0_valid}, 32'd1);
      chk("hold_data", {24'b0, data_out_0}, {24'b0, held});
    end
    last_acc = vin && data_in_0_ready;
    if (last_acc) exp_q.push_back(ref_model(din));
    if (data_out_0_valid && ordy) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", {31'b0, data_out_0_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", {24'b0, data_out_0}, {24'b0, e[7:0]});
        if (e[8]) begin
          if (m16 != 65535) m16++;
          if (m2 != 3) m2++;
        end
      end
    end
    if (clr) begin m16 = 0; m2 = 0; end
    stalled = data_out_0_valid && !ordy;
    held    = data_out_0;
    @(posedge clk);
    @(negedge clk);
    chk("sat_count", {16'b0, sat_count}, m16);
    chk("sat_count_w2", {30'b0, sat_count_w2}, m2);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk(tag, exp_q.size(), 0);
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic directed(input logic [IW-1:0] din, input logic [7:0] exp_out, input string tag);
    step(1'b1, din, 1'b1, 1'b0);
    chk({tag, "_lat1"}, {31'b0, data_out_0_valid}, 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk({tag, "_lat2"}, {31'b0, data_out_0_valid}, 32'd1);
    chk(tag, {24'b0, data_out_0}, {24'b0, exp_out});
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    int idx, guard, cnt;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'b0, data_out_0_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, data_in_0_ready}, 32'd0);
    chk("rst_out_data", {24'b0, data_out_0}, 32'd0);
    chk("rst_sat_count", {16'b0, sat_count}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", {31'b0, data_in_0_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_edge", {31'b0, data_in_0_ready}, 32'd1);

    directed(16'h0128, 8'h13, "q_0128");
    directed(16'hFFF8, 8'h00, "q_fff8");
    directed(16'hFFF7, 8'hFF, "q_fff7");
    chk("sat_none", {16'b0, sat_count}, 32'd0);
    directed(16'h7FFF, 8'h7F, "q_7fff");
    chk("sat_after_pos", {16'b0, sat_count}, 32'd1);
    directed(16'h8000, 8'h80, "q_8000");
    chk("sat_after_neg", {16'b0, sat_count}, 32'd2);

    idx = 0;
    guard = 0;
    while (idx < 100 && guard < 2000) begin
      step(1'b1, 16'(idx * 16 + int'($urandom_range(0, 7))), 1'($urandom_range(0, 1)), 1'b0);
      if (last_acc) idx++;
      guard++;
    end
    chk("stream_count", idx, 100);
    drain("stream_drain");

    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 16'($urandom), 1'b0, 1'b0);
      if (last_acc) cnt++;
    end
    chk("bp_accepted", cnt, 3);
    chk("bp_ready_low", {31'b0, data_in_0_ready}, 32'd0);
    drain("bp_drain");

    step(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++)
      step(1'b1, ($urandom_range(0, 1) != 0) ? 16'h7FF0 + 16'($urandom_range(8, 15))
                                             : 16'h8000 + 16'($urandom_range(0, 7)), 1'b1, 1'b0);
    drain("satw2_drain");
    chk("satw2_hold", {30'b0, sat_count_w2}, 32'd3);
    chk("sat16_five", {16'b0, sat_count}, 32'd5);
    step(1'b1, 16'h7FFF, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("clear_wins", {16'b0, sat_count}, 32'd0);
    chk("clear_wins_w2", {30'b0, sat_count_w2}, 32'd0);

    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 31) == 0));
    drain("rand_drain");

    step(1'b1, 16'h0355, 1'b1, 1'b0);
    step(1'b1, 16'h7FFF, 1'b1, 1'b0);
    rst_n = 1'b0;
    data_in_0_valid = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, data_out_0_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, data_in_0_ready}, 32'd0);
    chk("midrst_sat", {16'b0, sat_count}, 32'd0);
    exp_q.delete();
    m16 = 0;
    m2 = 0;
    stalled = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("post_rst_ready", {31'b0, data_in_0_ready}, 32'd1);
    directed(16'h0128, 8'h13, "post_rst_beat");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
